// File: rtl/memory_port_arbiter.sv
// Two-requester (fetch / data) arbiter for the single memory port, one transaction at a time.
// Optional fetch-starvation guard enabled by defining MEMORY_ARBITER_FAIRNESS_EN.
module memory_port_arbiter #(
  parameter int WIDTH           = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             fetch_enable,
  input  logic [WIDTH-1:0] fetch_address,
  input  logic             fetch_cancel,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] fetch_data,
  input  logic             data_enable,
  input  logic             data_write,
  input  logic [WIDTH-1:0] data_address,
  input  logic [WIDTH-1:0] data_write_data,
  output logic             data_valid,
  output logic [WIDTH-1:0] data_read_data,
  output logic             mem_enable,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic [WIDTH-1:0] mem_read_data,
  input  logic             mem_ack
);

  typedef enum logic [1:0] {IDLE, FETCH_BUSY, DATA_BUSY} state_t;

  state_t           state_q;
  logic             mem_enable_q, mem_write_q, fetch_valid_q, data_valid_q, discard_q;
  logic [WIDTH-1:0] mem_address_q, mem_write_data_q, fetch_data_q, data_read_data_q;
  logic             fetch_ok, fetch_turn, data_grant, fetch_grant;

  assign fetch_ok = fetch_enable & ~fetch_cancel;

`ifdef MEMORY_ARBITER_FAIRNESS_EN
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  logic [STREAK_W-1:0] streak_q, streak_d;

  assign fetch_turn = fetch_ok & data_enable & (streak_q == STREAK_W'(MAX_DATA_STREAK));

  // Counts data grants that overtook a waiting fetch; reset once fetch is served or gone.
  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE) begin
      if (fetch_grant || !fetch_ok) begin
        streak_d = '0;
      end else if (data_grant) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused = (MAX_DATA_STREAK > 0);
  assign fetch_turn = 1'b0;
`endif

  assign data_grant  = data_enable & ~fetch_turn;
  assign fetch_grant = fetch_ok & ~data_grant;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      mem_enable_q     <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      fetch_valid_q    <= 1'b0;
      fetch_data_q     <= '0;
      data_valid_q     <= 1'b0;
      data_read_data_q <= '0;
      discard_q        <= 1'b0;
    end else begin
      fetch_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_grant) begin
            state_q          <= DATA_BUSY;
            mem_enable_q     <= 1'b1;
            mem_write_q      <= data_write;
            mem_address_q    <= data_address;
            mem_write_data_q <= data_write_data;
          end else if (fetch_grant) begin
            state_q          <= FETCH_BUSY;
            mem_enable_q     <= 1'b1;
            mem_write_q      <= 1'b0;
            mem_address_q    <= fetch_address;
            mem_write_data_q <= '0;
            discard_q        <= 1'b0;
          end
        end
        FETCH_BUSY: begin
          // Memory cannot abort, so a cancelled fetch still waits for ack but is dropped.
          if (mem_ack) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            discard_q    <= 1'b0;
            if (!(discard_q || fetch_cancel)) begin
              fetch_valid_q <= 1'b1;
              fetch_data_q  <= mem_read_data;
            end
          end else if (fetch_cancel) begin
            discard_q <= 1'b1;
          end
        end
        DATA_BUSY: begin
          if (mem_ack) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            data_valid_q <= 1'b1;
            if (!mem_write_q) begin
              data_read_data_q <= mem_read_data;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_enable     = mem_enable_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign fetch_valid    = fetch_valid_q;
  assign fetch_data     = fetch_data_q;
  assign data_valid     = data_valid_q;
  assign data_read_data = data_read_data_q;

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch and the data-access stage (loads/stores from the read/write stages).
- Holds a one-transaction-at-a-time state machine, latches the winning request, and drives the external memory handshake.
- Returns read data to whichever requester owns the transaction.
- Discards fetch results when the pipeline redirects the PC mid-transaction.

Parameters:
- WIDTH, 32, width of addresses and data words (matches regval_t).
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending (used only with the optional feature).

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- fetch_enable  input  1  fetch requests a read; held until fetch_valid or fetch_cancel.
- fetch_address  input  WIDTH  fetch read address.
- fetch_cancel  input  1  PC is changing; abandon any pending or in-flight fetch.
- fetch_valid  output  1  one-cycle pulse: fetch_data is valid.
- fetch_data  output  WIDTH  instruction word returned.
- data_enable  input  1  data stage requests an access; held until data_valid.
- data_write  input  1  1 = store, 0 = load; sampled at grant.
- data_address  input  WIDTH  load/store address.
- data_write_data  input  WIDTH  store value.
- data_valid  output  1  one-cycle pulse: access complete; data_read_data valid for loads.
- data_read_data  output  WIDTH  load result.
- mem_enable  output  1  transaction active on memory port.
- mem_write  output  1  transaction is a store.
- mem_address  output  WIDTH  latched address.
- mem_write_data  output  WIDTH  latched store value.
- mem_read_data  input  WIDTH  memory read data, valid with mem_ack.
- mem_ack  input  1  memory completes the current transaction.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE. All outputs 0: mem_enable, mem_write, mem_address, mem_write_data, fetch_valid, fetch_data, data_valid, data_read_data. Discard flag cleared; streak counter cleared.
- States: IDLE, FETCH_BUSY, DATA_BUSY.
- IDLE, arbitration at a rising edge:
  - data_enable=1 wins over fetch_enable.
  - A fetch is granted only if fetch_enable=1 and fetch_cancel=0.
  - On grant, mem_address and mem_write_data are latched; mem_write = data_write for a data grant, 0 for a fetch grant.
  - mem_enable goes to 1 in the next cycle (registered) and the state moves to the matching BUSY state.
- BUSY, edge with mem_ack=1:
  - mem_enable goes to 0 and the state returns to IDLE.
  - The owner's valid pulses for exactly one cycle, with the data registered from mem_read_data.
  - Stores pulse data_valid; data_read_data is left unchanged.
- Latency: request seen at edge N -> mem_enable from N+1 -> ack at edge M -> valid high during cycle M+1.
- IDLE lasts at least one cycle between transactions, so back-to-back throughput is one transaction per (ack latency + 2) cycles.
- BUSY with mem_ack=0: all mem_* outputs hold stable. Requesters must hold their inputs; changes are ignored after grant.
- fetch_cancel=1 at any edge while in FETCH_BUSY: the transaction still runs to mem_ack (memory cannot be aborted), a discard flag is set, and fetch_valid is suppressed on completion.
- fetch_cancel and mem_ack in the same edge: fetch_valid is suppressed.
- mem_ack while IDLE: ignored.
- Reset mid-transaction: immediate return to IDLE. Any pending valid is lost.

Optional Feature:
- Macro: MEMORY_ARBITER_FAIRNESS_EN.
- Defined:
  - A counter (clog2(MAX_DATA_STREAK+1) bits) increments on each data grant made while fetch_enable=1 and fetch_cancel=0.
  - It clears on any fetch grant, or when no fetch is pending in IDLE.
  - When the counter equals MAX_DATA_STREAK and both requesters are pending, fetch wins.
- Undefined: strict data priority; the counter logic is absent.

Test Plan:
- Fetch-only read: fetch_enable=1, address 0x100, ack 2 cycles after mem_enable with 0xDEADBEEF -> mem_address=0x100, mem_write=0, one-cycle fetch_valid with fetch_data=0xDEADBEEF, data_valid stays 0.
- Simultaneous requests: fetch 0x200 and data load 0x8000 in the same cycle, ack returns 0x1234 -> data granted first (mem_address=0x8000), data_valid with 0x1234; fetch granted after the IDLE cycle.
- Store: data_write=1, address 0x40, value 0xCAFEF00D -> mem_write=1, mem_write_data=0xCAFEF00D; data_valid pulses; data_read_data unchanged from its previous value.
- Cancel in flight: fetch granted, fetch_cancel pulsed one cycle before mem_ack -> no fetch_valid; state returns to IDLE; the next fetch to 0x300 completes normally.
- Reset mid-transaction: reset_n low during DATA_BUSY -> all outputs 0 immediately; after release, no spurious data_valid even when mem_ack is asserted.
- With MEMORY_ARBITER_FAIRNESS_EN and MAX_DATA_STREAK=4: data and fetch requests continuously asserted -> the grant order is 4 data grants, then 1 fetch, then repeats. Without the macro, fetch is never granted while data_enable=1.
